// File: rtl/cep_encoder_if.sv
// -----------------------------------------------------------------------------
// cep_defs_pkg / cep_encoder_if
//
// Purpose:
//   cep_defs_pkg holds the CEP packet geometry and header field placement.
//   The CEP decoder unpacks using the same placement.
//   cep_encoder_if bundles the three handshakes of the CEP packet builder:
//   the header beat, the payload word stream, and the packet output.
//
// Packet geometry:
//   512-bit packet made of eight 64-bit word slots.
//   Slot 0 holds the class bits and the small header fields.
//   Slot 1 holds addr.
//   Slot 2 is reserved header space for requests.
//   Request data occupies slots 3-7.
//   Response/interrupt data occupies slots 1-7.
//
// Modports:
//   master : the packet source and link side.
//            Drives the header fields, the payload words and cep_rdy.
//   slave  : the encoder.
//            Drives hdr_rdy, word_rdy, cep_val, cep_pkg and len_clamped.
// -----------------------------------------------------------------------------
package cep_defs_pkg;
  localparam int CEP_DATA_WIDTH         = 512;
  localparam int CEP_WORD_WIDTH         = 64;

  localparam int CEP_IS_REQ             = 0;
  localparam int CEP_IS_RESP            = 1;
  localparam int CEP_IS_INT             = 2;
  localparam int CEP_LAST_SUBLINE       = 3;
  localparam int CEP_LAST_SUBLINE_WIDTH = 1;
  localparam int CEP_SUBLINE_ID_LO      = 4;
  localparam int CEP_SUBLINE_ID_WIDTH   = 2;
  localparam int CEP_MESI_LO            = 6;
  localparam int CEP_MESI_WIDTH         = 2;
  localparam int CEP_MSHRID_LO          = 8;
  localparam int CEP_MSHRID_WIDTH       = 8;
  localparam int CEP_MSG_TYPE_LO        = 16;
  localparam int CEP_MSG_TYPE_WIDTH     = 8;
  localparam int CEP_DATA_SIZE_LO       = 24;
  localparam int CEP_DATA_SIZE_WIDTH    = 3;
  localparam int CEP_CACHE_TYPE         = 27;
  localparam int CEP_CACHE_TYPE_WIDTH   = 1;
  localparam int CEP_INT_ID_LO          = 28;
  localparam int CEP_INT_ID_WIDTH       = 4;
  localparam int CEP_SRC_CHIPID_LO      = 32;
  localparam int CEP_SRC_CHIPID_WIDTH   = 16;
  localparam int CEP_ADDR_LO            = 64;
  localparam int CEP_ADDR_WIDTH         = 48;
endpackage

interface cep_encoder_if;
  import cep_defs_pkg::*;

  // header beat
  logic                              hdr_val;
  logic                              hdr_rdy;
  logic                              is_request;
  logic                              is_response;
  logic                              is_int;
  logic [CEP_LAST_SUBLINE_WIDTH-1:0] last_subline;
  logic [CEP_SUBLINE_ID_WIDTH-1:0]   subline_id;
  logic [CEP_MESI_WIDTH-1:0]         mesi;
  logic [CEP_MSHRID_WIDTH-1:0]       mshrid;
  logic [CEP_MSG_TYPE_WIDTH-1:0]     msg_type;
  logic [CEP_DATA_SIZE_WIDTH-1:0]    data_size;
  logic [CEP_CACHE_TYPE_WIDTH-1:0]   cache_type;
  logic [CEP_ADDR_WIDTH-1:0]         addr;
  logic [CEP_SRC_CHIPID_WIDTH-1:0]   src_chipid;
  logic [CEP_INT_ID_WIDTH-1:0]       int_id;
  logic [2:0]                        num_words;

  // payload words
  logic                              word_val;
  logic                              word_rdy;
  logic [CEP_WORD_WIDTH-1:0]         word_data;

  // packet output
  logic                              cep_val;
  logic                              cep_rdy;
  logic [CEP_DATA_WIDTH-1:0]         cep_pkg;
  logic                              len_clamped;

  modport master (
    output hdr_val, is_request, is_response, is_int, last_subline, subline_id,
           mesi, mshrid, msg_type, data_size, cache_type, addr, src_chipid,
           int_id, num_words, word_val, word_data, cep_rdy,
    input  hdr_rdy, word_rdy, cep_val, cep_pkg, len_clamped
  );

  modport slave (
    input  hdr_val, is_request, is_response, is_int, last_subline, subline_id,
           mesi, mshrid, msg_type, data_size, cache_type, addr, src_chipid,
           int_id, num_words, word_val, word_data, cep_rdy,
    output hdr_rdy, word_rdy, cep_val, cep_pkg, len_clamped
  );
endinterface

// File: rtl/cep_encoder.sv
// -----------------------------------------------------------------------------
// cep_encoder
//
// Purpose:
//   Serializing CEP packet builder. It accepts one header beat, then up to
//   seven payload words. It assembles them into one CEP_DATA_WIDTH packet.
//   The packet is held on a valid/ready output until the link takes it.
//
// Ports:
//   clk    : block clock
//   rst_n  : asynchronous active-low reset
//   bus    : cep_encoder_if.slave, which carries three handshakes:
//              header beat  : hdr_val/hdr_rdy plus the header fields
//              payload word : word_val/word_rdy/word_data
//              packet out   : cep_val/cep_rdy/cep_pkg
//            It also carries len_clamped, a one-cycle flag raised when
//            num_words exceeded the class maximum.
// -----------------------------------------------------------------------------
module cep_encoder
  import cep_defs_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  cep_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SEND    = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    next_state_s;

  logic [CEP_DATA_WIDTH-1:0] pkg_r;
  logic [2:0]                base_r;        // first data slot of the packet
  logic [2:0]                tgt_r;         // payload words to collect
  logic [2:0]                cnt_r;         // payload words collected so far
  logic                      len_clamped_r;

  logic                      hdr_rdy_s;
  logic                      word_rdy_s;
  logic                      cep_val_s;
  logic                      hdr_fire_s;
  logic                      word_fire_s;
  logic                      last_word_s;

  logic [2:0]                hdr_max_s;
  logic                      hdr_clamp_s;
  logic [2:0]                hdr_tgt_s;
  logic [2:0]                hdr_base_s;
  logic [CEP_DATA_WIDTH-1:0] hdr_image_s;
  logic [2:0]                slot_s;
  logic [CEP_DATA_WIDTH-1:0] word_image_s;

  assign hdr_fire_s  = bus.hdr_val & hdr_rdy_s;
  assign word_fire_s = bus.word_val & word_rdy_s;
  // tgt_r is at least 1 whenever COLLECT is active, so the subtraction cannot underflow there.
  assign last_word_s = (cnt_r == (tgt_r - 3'd1));

  assign bus.hdr_rdy     = hdr_rdy_s;
  assign bus.word_rdy    = word_rdy_s;
  assign bus.cep_val     = cep_val_s;
  assign bus.cep_pkg     = pkg_r;
  assign bus.len_clamped = len_clamped_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hdr_fire_s) begin
          if (hdr_tgt_s == 3'd0) begin
            next_state_s = ST_SEND;
          end else begin
            next_state_s = ST_COLLECT;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (word_fire_s && last_word_s) begin
          next_state_s = ST_SEND;
        end else begin
          next_state_s = ST_COLLECT;
        end
      end
      ST_SEND: begin
        if (bus.cep_rdy) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_SEND;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded purely from the state register.
  always_comb begin
    hdr_rdy_s  = 1'b0;
    word_rdy_s = 1'b0;
    cep_val_s  = 1'b0;
    case (state_r)
      ST_IDLE:    hdr_rdy_s  = 1'b1;
      ST_COLLECT: word_rdy_s = 1'b1;
      ST_SEND:    cep_val_s  = 1'b1;
      default: begin
        hdr_rdy_s  = 1'b0;
        word_rdy_s = 1'b0;
        cep_val_s  = 1'b0;
      end
    endcase
  end

  // Header decode: class maximum, clamped word target, data slot base.
  // A request wins over the other class bits when several are set.
  always_comb begin
    if (bus.is_request) begin
      hdr_max_s  = 3'd5;
      hdr_base_s = 3'd3;
    end else begin
      hdr_max_s  = 3'd7;
      hdr_base_s = 3'd1;
    end
    hdr_clamp_s = (bus.num_words > hdr_max_s);
    if (hdr_clamp_s) begin
      hdr_tgt_s = hdr_max_s;
    end else begin
      hdr_tgt_s = bus.num_words;
    end
  end

  // Header image: a zeroed packet with every header field in place.
  // Starting from zero guarantees no residue from the previous packet.
  always_comb begin
    hdr_image_s = '0;
    hdr_image_s[CEP_IS_REQ]       = bus.is_request;
    hdr_image_s[CEP_IS_RESP]      = bus.is_response;
    hdr_image_s[CEP_IS_INT]       = bus.is_int;
    hdr_image_s[CEP_LAST_SUBLINE +: CEP_LAST_SUBLINE_WIDTH] = bus.last_subline;
    hdr_image_s[CEP_SUBLINE_ID_LO +: CEP_SUBLINE_ID_WIDTH]  = bus.subline_id;
    hdr_image_s[CEP_MESI_LO +: CEP_MESI_WIDTH]              = bus.mesi;
    hdr_image_s[CEP_MSHRID_LO +: CEP_MSHRID_WIDTH]          = bus.mshrid;
    hdr_image_s[CEP_MSG_TYPE_LO +: CEP_MSG_TYPE_WIDTH]      = bus.msg_type;
    hdr_image_s[CEP_DATA_SIZE_LO +: CEP_DATA_SIZE_WIDTH]    = bus.data_size;
    hdr_image_s[CEP_CACHE_TYPE +: CEP_CACHE_TYPE_WIDTH]     = bus.cache_type;
    hdr_image_s[CEP_INT_ID_LO +: CEP_INT_ID_WIDTH]          = bus.int_id;
    hdr_image_s[CEP_SRC_CHIPID_LO +: CEP_SRC_CHIPID_WIDTH]  = bus.src_chipid;
    hdr_image_s[CEP_ADDR_LO +: CEP_ADDR_WIDTH]              = bus.addr;
  end

  // Word insert: the current packet with the incoming word written into slot base+cnt.
  // base+cnt stays at or below 7 because tgt is clamped per class.
  always_comb begin
    slot_s       = base_r + cnt_r;
    word_image_s = pkg_r;
    word_image_s[int'(slot_s) * CEP_WORD_WIDTH +: CEP_WORD_WIDTH] = bus.word_data;
  end

  // Packet register and collection bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkg_r         <= '0;
      base_r        <= 3'd0;
      tgt_r         <= 3'd0;
      cnt_r         <= 3'd0;
      len_clamped_r <= 1'b0;
    end else begin
      len_clamped_r <= hdr_fire_s & hdr_clamp_s;
      if (hdr_fire_s) begin
        pkg_r  <= hdr_image_s;
        base_r <= hdr_base_s;
        tgt_r  <= hdr_tgt_s;
        cnt_r  <= 3'd0;
      end else if (word_fire_s) begin
        pkg_r <= word_image_s;
        // The counter holds on the final word, so it peaks at 6 and never wraps.
        if (!last_word_s) begin
          cnt_r <= cnt_r + 3'd1;
        end else begin
          cnt_r <= cnt_r;
        end
      end else begin
        pkg_r <= pkg_r;
        cnt_r <= cnt_r;
      end
    end
  end

endmodule
